// File: rtl/freq_divider.sv
// Integer frequency divider: derives a slow, registered, glitch-free square
// wave from the reference clock. The output is low for LOW cycles, then high
// for HIGH cycles, so the period is DIV cycles.
module freq_divider #(
    parameter int unsigned IN_FREQ  = 50_000_000,
    parameter int unsigned OUT_FREQ = 480_000
) (
    input  logic clk_freq1,
    input  logic rst_n_key1,
    output logic freq_2
);

    // Division ratio, truncated; guarded so a zero OUT_FREQ cannot divide by zero
    localparam int unsigned RATIO = (OUT_FREQ == 0) ? 0 : (IN_FREQ / OUT_FREQ);
    // Ratios below 2 (including OUT_FREQ > IN_FREQ) clamp to a toggle every cycle
    localparam int unsigned DIV   = (RATIO < 2) ? 2 : RATIO;
    // Odd DIV puts the extra cycle in the low phase
    localparam int unsigned HIGH  = DIV / 2;
    localparam int unsigned LOW   = DIV - HIGH;
    // LOW >= HIGH, so LOW-1 is the largest value the counter ever holds
    localparam int unsigned CW    = ($clog2(LOW) < 1) ? 1 : $clog2(LOW);

    // Reject nonsensical frequencies at elaboration time
    generate
        if (IN_FREQ == 0 || OUT_FREQ == 0) begin : g_bad_freq
            $error("freq_divider: IN_FREQ and OUT_FREQ must both be non-zero");
        end
    endgenerate

    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          freq_2_q;
    logic          freq_2_d;

    // Phase counter and output: flip phase at the end of each half period
    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        freq_2_d = freq_2_q;
        if (!freq_2_q && (cnt_q == LOW_LAST)) begin
            cnt_d    = '0;
            freq_2_d = 1'b1;
        end else if (freq_2_q && (cnt_q == HIGH_LAST)) begin
            cnt_d    = '0;
            freq_2_d = 1'b0;
        end
    end

    // State register; reset restarts the waveform at the beginning of the low phase
    always_ff @(posedge clk_freq1 or negedge rst_n_key1) begin
        if (!rst_n_key1) begin
            cnt_q    <= '0;
            freq_2_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            freq_2_q <= freq_2_d;
        end
    end

    assign freq_2 = freq_2_q;

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider: default ratio (DIV=104), odd ratio (DIV=7)
// and clamped ratio (DIV=2), including an asynchronous reset pulse mid-phase.
module tb_freq_divider;

    logic clk;
    logic rst_n_def;
    logic rst_n_odd;
    logic rst_n_clp;
    logic f_def;
    logic f_odd;
    logic f_clp;

    int n_cmp  = 0;
    int n_fail = 0;

    freq_divider u_def (
        .clk_freq1  (clk),
        .rst_n_key1 (rst_n_def),
        .freq_2     (f_def)
    );

    freq_divider #(50, 7) u_odd (
        .clk_freq1  (clk),
        .rst_n_key1 (rst_n_odd),
        .freq_2     (f_odd)
    );

    freq_divider #(10, 10) u_clp (
        .clk_freq1  (clk),
        .rst_n_key1 (rst_n_clp),
        .freq_2     (f_clp)
    );

    // 40 ns reference clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count rising edges until the selected output reaches val (bounded)
    task automatic count_until(input int sel, input logic val, output int n);
        logic cur;
        n = 0;
        do begin
            step();
            n++;
            cur = (sel == 0) ? f_def : ((sel == 1) ? f_odd : f_clp);
        end while (cur !== val && n < 400);
    endtask

    initial begin
        int n;
        int hi;
        int lo;
        logic exp_t;

        rst_n_def = 1'b0;
        rst_n_odd = 1'b0;
        rst_n_clp = 1'b0;

        // T1: held in reset with the clock running
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_def_out", 32'(f_def), 32'd0);
            check("t1_def_cnt", 32'(u_def.cnt_q), 32'd0);
            check("t1_odd_out", 32'(f_odd), 32'd0);
            check("t1_clp_out", 32'(f_clp), 32'd0);
        end

        // T2: release between edges, first rise on the 52nd edge
        #9 rst_n_def = 1'b1;
        count_until(0, 1'b1, n);
        check("t2_first_rise", 32'(n), 32'd52);

        // T3: ten steady periods of 52 high + 52 low
        for (int i = 0; i < 10; i++) begin
            count_until(0, 1'b0, hi);
            count_until(0, 1'b1, lo);
            check("t3_high", 32'(hi), 32'd52);
            check("t3_low", 32'(lo), 32'd52);
            check("t3_period", 32'(hi + lo), 32'd104);
        end

        // T4: odd ratio DIV=7 -> low 4, high 3
        #9 rst_n_odd = 1'b1;
        count_until(1, 1'b1, n);
        check("t4_first_low", 32'(n), 32'd4);
        for (int i = 0; i < 3; i++) begin
            count_until(1, 1'b0, hi);
            count_until(1, 1'b1, lo);
            check("t4_high", 32'(hi), 32'd3);
            check("t4_low", 32'(lo), 32'd4);
            check("t4_period", 32'(hi + lo), 32'd7);
        end

        // T5: clamp DIV=2 -> toggles on every rising edge, starting high
        #9 rst_n_clp = 1'b1;
        exp_t = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_toggle", 32'(f_clp), 32'(exp_t));
            exp_t = ~exp_t;
        end

        // T6: 5 ns reset pulse mid-high, between clock edges
        count_until(0, 1'b1, n);
        check("t6_reach_high", 32'(f_def), 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("t6_still_high", 32'(f_def), 32'd1);
        #5 rst_n_def = 1'b0;
        #2;
        check("t6_async_out", 32'(f_def), 32'd0);
        check("t6_async_cnt", 32'(u_def.cnt_q), 32'd0);
        #3 rst_n_def = 1'b1;
        #1;
        check("t6_after_release", 32'(f_def), 32'd0);
        count_until(0, 1'b1, n);
        check("t6_full_low", 32'(n), 32'd52);
        count_until(0, 1'b0, hi);
        check("t6_high_after", 32'(hi), 32'd52);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
